// File: rtl/systolic_seq_ctrl_if.sv
// systolic_seq_ctrl_if: command, array-strobe and drain handshake bundle for the tile sequencer.
interface systolic_seq_ctrl_if #(
   parameter int ROWS   = 4,
   parameter int KDIM_W = 8
);
   localparam int RW = $clog2(ROWS);
   logic              start;
   logic [KDIM_W-1:0] k_len;
   logic              busy;
   logic              done;
   logic              err;
   logic              w_load_en;
   logic [RW-1:0]     w_row_sel;
   logic              acc_clear;
   logic              a_valid;
   logic [KDIM_W-1:0] a_k_idx;
   logic              acc_en;
   logic              drain_valid;
   logic [RW-1:0]     drain_row;
   logic              drain_ready;
   modport master (
      output start, k_len, drain_ready,
      input  busy, done, err, w_load_en, w_row_sel, acc_clear,
             a_valid, a_k_idx, acc_en, drain_valid, drain_row
   );
   modport slave (
      input  start, k_len, drain_ready,
      output busy, done, err, w_load_en, w_row_sel, acc_clear,
             a_valid, a_k_idx, acc_en, drain_valid, drain_row
   );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: sequences one weight-stationary tile pass (load, compute+skew, drain, done).
module systolic_seq_ctrl #(
   parameter int ROWS   = 4,
   parameter int COLS   = 4,
   parameter int KDIM_W = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   systolic_seq_ctrl_if.slave  bus
);
   localparam int CNT_W = KDIM_W + $clog2(ROWS + COLS) + 1;
   localparam int RW    = $clog2(ROWS);
   typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, DONE} state_e;
   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [KDIM_W-1:0] klen_q, klen_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  klen_w, comp_last, row_last;
   logic              row_end, comp_end, a_act;
   // Counter is widened so klen_q plus the skew flush never wraps.
   assign klen_w    = CNT_W'(klen_q);
   assign comp_last = klen_w + CNT_W'(ROWS + COLS - 3);
   assign row_last  = CNT_W'(ROWS - 1);
   assign row_end   = cnt_q == row_last;
   assign comp_end  = cnt_q == comp_last;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         klen_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         klen_q  <= klen_d;
         err_q   <= err_d;
      end
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      klen_d  = klen_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            err_d   = bus.start && bus.k_len == '0;
            state_d = (bus.start && bus.k_len != '0) ? LOAD : IDLE;
            klen_d  = (bus.start && bus.k_len != '0) ? bus.k_len : klen_q;
            cnt_d   = '0;
         end
         LOAD: begin
            state_d = row_end ? COMPUTE : LOAD;
            cnt_d   = row_end ? '0 : cnt_q + 1'b1;
         end
         COMPUTE: begin
            state_d = comp_end ? DRAIN : COMPUTE;
            cnt_d   = comp_end ? '0 : cnt_q + 1'b1;
         end
         DRAIN: begin
            // Row index only moves on an accepted handshake; no timeout.
            state_d = (bus.drain_ready && row_end) ? DONE : DRAIN;
            cnt_d   = bus.drain_ready ? (row_end ? '0 : cnt_q + 1'b1) : cnt_q;
         end
         DONE: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end
   assign a_act = state_q == COMPUTE && cnt_q < klen_w;
   always_comb begin
      bus.busy        = state_q != IDLE;
      bus.done        = state_q == DONE;
      bus.err         = err_q;
      bus.w_load_en   = state_q == LOAD;
      bus.w_row_sel   = state_q == LOAD ? cnt_q[RW-1:0] : '0;
      bus.acc_clear   = state_q == LOAD && cnt_q == '0;
      bus.a_valid     = a_act;
      bus.a_k_idx     = a_act ? cnt_q[KDIM_W-1:0] : '0;
      bus.acc_en      = state_q == COMPUTE;
      bus.drain_valid = state_q == DRAIN;
      bus.drain_row   = state_q == DRAIN ? cnt_q[RW-1:0] : '0;
   end
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb_systolic_seq_ctrl: cycle-exact scoreboard of expected output vectors built from phase lengths.
module tb_systolic_seq_ctrl;
   localparam int ROWS   = 4;
   localparam int COLS   = 4;
   localparam int KDIM_W = 8;
   localparam int RW     = $clog2(ROWS);
   typedef struct packed {
      logic              busy;
      logic              done;
      logic              err;
      logic              w_load_en;
      logic [RW-1:0]     w_row_sel;
      logic              acc_clear;
      logic              a_valid;
      logic [KDIM_W-1:0] a_k_idx;
      logic              acc_en;
      logic              drain_valid;
      logic [RW-1:0]     drain_row;
   } out_t;
   typedef struct {
      int   cyc;
      out_t v;
   } rec_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fails = 0;
   rec_t q[$];
   systolic_seq_ctrl_if #(.ROWS(ROWS), .KDIM_W(KDIM_W)) bus ();
   systolic_seq_ctrl #(.ROWS(ROWS), .COLS(COLS), .KDIM_W(KDIM_W)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic out_t sample();
      out_t o;
      o.busy        = bus.busy;
      o.done        = bus.done;
      o.err         = bus.err;
      o.w_load_en   = bus.w_load_en;
      o.w_row_sel   = bus.w_row_sel;
      o.acc_clear   = bus.acc_clear;
      o.a_valid     = bus.a_valid;
      o.a_k_idx     = bus.a_k_idx;
      o.acc_en      = bus.acc_en;
      o.drain_valid = bus.drain_valid;
      o.drain_row   = bus.drain_row;
      return o;
   endfunction
   task automatic check(string name, out_t got, out_t exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask
   always @(negedge clk) begin
      out_t got, exp;
      got = sample();
      while (q.size() > 0 && q[0].cyc < cyc) begin
         n_checks++;
         n_fails++;
         $display("FAIL stale_record: expected record for cycle %0d never consumed (now %0d)", q[0].cyc, cyc);
         void'(q.pop_front());
      end
      exp = '0;
      if (q.size() > 0 && q[0].cyc == cyc) exp = q.pop_front().v;
      check($sformatf("cycle_%0d", cyc), got, exp);
   end
   task automatic push(int c, out_t v);
      rec_t r;
      r.cyc = c;
      r.v   = v;
      q.push_back(r);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   // mode: 0 always ready, 1 stalled for first three drain cycles, 2 random.
   // abort: nonzero resets asynchronously on that compute cycle offset.
   task automatic run_pass(int k, int mode, bit ign, int abort);
      int rdy[$];
      int acc, s, c0, len, d0, e, row;
      out_t v;
      acc = 0;
      while (acc < ROWS) begin
         int b;
         b = mode == 0 ? 1 : mode == 1 ? int'(rdy.size() >= 3) : int'($urandom_range(0, 1));
         rdy.push_back(b);
         acc += b;
      end
      s   = cyc;
      c0  = s + ROWS + 1;
      len = k + ROWS + COLS - 2;
      d0  = c0 + len;
      e   = d0 + rdy.size();
      for (int r = 0; r < ROWS; r++) begin
         v = '0;
         v.busy = 1'b1;
         v.w_load_en = 1'b1;
         v.w_row_sel = RW'(r);
         v.acc_clear = r == 0;
         push(s + 1 + r, v);
      end
      for (int j = 0; j < len; j++) begin
         v = '0;
         v.busy = 1'b1;
         v.acc_en = 1'b1;
         v.a_valid = j < k;
         v.a_k_idx = j < k ? KDIM_W'(j) : '0;
         push(c0 + j, v);
      end
      row = 0;
      for (int i = 0; i < rdy.size(); i++) begin
         v = '0;
         v.busy = 1'b1;
         v.drain_valid = 1'b1;
         v.drain_row = RW'(row);
         push(d0 + i, v);
         row += rdy[i];
      end
      v = '0;
      v.busy = 1'b1;
      v.done = 1'b1;
      push(e, v);
      bus.start = 1'b1;
      bus.k_len = KDIM_W'(k);
      bus.drain_ready = 1'($urandom_range(0, 1));
      for (int t = s + 1; t <= e; t++) begin
         tick();
         bus.start = ign && (t == c0 + 1 || t == e);
         bus.k_len = KDIM_W'($urandom_range(0, 255));
         bus.drain_ready = (t >= d0 && t < e) ? 1'(rdy[t - d0]) : 1'($urandom_range(0, 1));
         if (abort != 0 && t == c0 + abort) begin
            #2;
            rst_n = 1'b0;
            #1;
            check("async_reset_outputs", sample(), '0);
            q.delete();
            bus.start = 1'b0;
            tick();
            tick();
            #2;
            rst_n = 1'b1;
            return;
         end
      end
      tick();
      bus.start = 1'b0;
   endtask
   task automatic run_err();
      out_t v;
      v = '0;
      v.err = 1'b1;
      push(cyc + 1, v);
      bus.start = 1'b1;
      bus.k_len = '0;
      tick();
      bus.start = 1'b0;
      bus.k_len = 8'd9;
      tick();
      tick();
   endtask
   initial begin
      bus.start = 1'b0;
      bus.k_len = '0;
      bus.drain_ready = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      tick();
      run_pass(3, 0, 1'b0, 0);
      tick();
      run_pass(3, 1, 1'b0, 0);
      tick();
      run_err();
      run_pass(4, 0, 1'b1, 0);
      repeat (3) tick();
      run_pass(5, 2, 1'b0, 3);
      tick();
      run_pass(1, 0, 1'b0, 0);
      tick();
      run_pass(255, 2, 1'b0, 0);
      for (int n = 0; n < 15; n++) begin
         repeat ($urandom_range(0, 2)) tick();
         if ($urandom_range(0, 4) == 0) run_err();
         run_pass($urandom_range(1, 12), 2, 1'($urandom_range(0, 1)), 0);
      end
      repeat (4) tick();
      n_checks++;
      if (q.size() != 0) begin
         n_fails++;
         $display("FAIL queue_drained: %0d records left, expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
Sequencer for one tile pass of the ROWS x COLS weight-stationary systolic PE array. A single start runs four phases in order: load weights row by row, stream K activation columns plus pipeline skew, drain result rows under downstream backpressure, then signal done. The block sits between the host/command interface and the array datapath. It owns only control strobes and indices; no data passes through it.

Parameters:
ROWS, 4, number of PE rows (>=2)
COLS, 4, number of PE columns (>=2)
KDIM_W, 8, width of the k_len command field
CNT_W, KDIM_W+$clog2(ROWS+COLS)+1, internal phase counter width (derived, not overridable)

Ports:
clock  in  1  single clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset (asserted at 0)
start  in  1  command strobe; sampled only in IDLE
k_len  in  KDIM_W  reduction length; sampled with start
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse; pass complete
err  out  1  one-cycle pulse; start rejected because k_len==0
w_load_en  out  1  weight-row write strobe to the array
w_row_sel  out  $clog2(ROWS)  weight row being written
acc_clear  out  1  clear all PE accumulators
a_valid  out  1  activation column valid at the array edge
a_k_idx  out  KDIM_W  activation column index
acc_en  out  1  PE accumulate enable
drain_valid  out  1  result row offered downstream
drain_row  out  $clog2(ROWS)  result row index
drain_ready  in  1  downstream accepts the result row

Behaviour:
- Reset (reset==0, async): state=IDLE, all counters 0, all outputs 0. Deassertion is synchronised externally.
- All outputs are registered or decoded from registered state and counters. There is no combinational path from any input to any output.
- States: IDLE, LOAD, COMPUTE, DRAIN, DONE.
- IDLE: if start && k_len!=0, latch k_len into klen_q and go to LOAD. If start && k_len==0, pulse err for 1 cycle and stay in IDLE.
- start in any non-IDLE state is ignored. It is not queued.
- LOAD: lasts exactly ROWS cycles. w_load_en=1 and w_row_sel = 0..ROWS-1. acc_clear=1 only in the first LOAD cycle. After the last row, go to COMPUTE.
- COMPUTE: lasts exactly klen_q+ROWS+COLS-2 cycles. acc_en=1 every cycle. a_valid=1 with a_k_idx=cycle index for the first klen_q cycles, then a_valid=0 and a_k_idx=0 for the skew flush. Then go to DRAIN.
- DRAIN: drain_valid=1, drain_row starts at 0. drain_row advances only on drain_valid && drain_ready.
  - drain_row and drain_valid hold while drain_ready=0, with no timeout.
  - After row ROWS-1 is accepted, go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE. busy is still 1 in DONE.
- Counter arithmetic is unsigned at CNT_W, so klen_q+ROWS+COLS-2 cannot overflow. klen_q=2^KDIM_W-1 must work.
- Index outputs are 0 whenever their qualifying strobe is 0.
- Reset asserted mid-pass aborts immediately to IDLE with outputs 0. The next start runs a full pass from LOAD.

Test Plan:
- ROWS=COLS=4, start with k_len=3 at cycle 0, drain_ready=1 -> LOAD cycles 1-4 (w_row_sel 0,1,2,3; acc_clear only at 1); COMPUTE 5-13 (a_valid 5-7 with a_k_idx 0,1,2; acc_en 5-13); DRAIN 14-17; done at 18; busy low at 19.
- Same pass with drain_ready=0 for cycles 14-16 -> drain_row stays 0 and drain_valid stays 1 through 16; rows 0-3 accepted 17-20; done at 21.
- start with k_len=0 -> err=1 for one cycle, busy stays 0, no strobes asserted.
- start pulsed again during COMPUTE and during DONE -> ignored; exactly one done pulse; no second pass begins.
- reset driven 0 asynchronously mid-COMPUTE (between clock edges) -> all outputs 0 immediately; after release, a start with k_len=1 gives a full pass with COMPUTE of 7 cycles.
- k_len=255 -> COMPUTE lasts 261 cycles; a_k_idx reaches 254 and does not wrap; done asserts.
